// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared constants, state encoding and helpers for the divider
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITER  = 32;
    localparam int CNT_W     = $clog2(DIV_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    // Two's-complement magnitude; 0x80000000 maps to itself and is then read as unsigned.
    function automatic logic [DIV_WIDTH-1:0] magnitude(input logic [DIV_WIDTH-1:0] v,
                                                       input logic                 neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - combinational 33-bit trial subtract with borrow-out
module div_step
    import div_unit_pkg::*;
(
    input  logic [DIV_WIDTH:0]   trial_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output logic [DIV_WIDTH-1:0] diff_o,
    output logic                 borrow_o
);

    // The partial remainder stays below the divisor, so a successful subtract never sets bit 32.
    logic diff_unused_msb;

    assign {borrow_o, diff_unused_msb, diff_o} = {1'b0, trial_i} - {2'b00, divisor_i};

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - 32-bit restoring divider, signed/unsigned, one quotient bit per cycle
module div_unit
    import div_unit_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [DIV_WIDTH-1:0] a,
    input  logic [DIV_WIDTH-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic                 div_by_zero,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder
);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
    logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
    logic [DIV_WIDTH-1:0] a_raw_q, a_raw_d;
    logic                 a_neg_q, a_neg_d;
    logic                 b_neg_q, b_neg_d;
    logic                 zero_q, zero_d;
    logic [DIV_WIDTH-1:0] quot_q, quot_d;
    logic [DIV_WIDTH-1:0] remd_q, remd_d;
    logic                 dbz_q, dbz_d;

    logic [DIV_WIDTH:0]   trial;
    logic [DIV_WIDTH-1:0] step_diff;
    logic                 step_borrow;

    assign trial = {rem_q, dvd_q[DIV_WIDTH-1]};

    div_step u_step (
        .trial_i   (trial),
        .divisor_i (dvs_q),
        .diff_o    (step_diff),
        .borrow_o  (step_borrow)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        a_raw_d = a_raw_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_neg_d = signed_op & a[DIV_WIDTH-1];
                    b_neg_d = signed_op & b[DIV_WIDTH-1];
                    dvd_d   = magnitude(a, signed_op & a[DIV_WIDTH-1]);
                    dvs_d   = magnitude(b, signed_op & b[DIV_WIDTH-1]);
                    a_raw_d = a;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(DIV_ITER - 1);
                    zero_d  = (b == '0);
                    state_d = (b == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                rem_d   = step_borrow ? trial[DIV_WIDTH-1:0] : step_diff;
                dvd_d   = {dvd_q[DIV_WIDTH-2:0], ~step_borrow};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (zero_q) begin
                    quot_d = '1;
                    remd_d = a_raw_q;
                    dbz_d  = 1'b1;
                end else begin
                    // Sign flags are only ever set for signed operations.
                    quot_d = (a_neg_q ^ b_neg_q) ? -dvd_q : dvd_q;
                    remd_d = a_neg_q ? -rem_q : rem_q;
                    dbz_d  = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            a_raw_q <= '0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            a_raw_q <= a_raw_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == FIX);
    assign done        = (state_q == DONE);
    assign div_by_zero = dbz_q;
    assign quotient    = quot_q;
    assign remainder   = remd_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with directed vectors
module tb_div_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    div_unit dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .signed_op   (signed_op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          start_edge;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_done   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest pending expectation.
    initial begin
        logic done_prev;
        exp_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (done === 1'b1) begin
                chk("done_one_cycle", {31'b0, done_prev}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pending operation", cyc);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_quotient"}, quotient, e.q);
                    chk({e.name, "_remainder"}, remainder, e.r);
                    chk({e.name, "_div_by_zero"}, {31'b0, div_by_zero}, {31'b0, e.dbz});
                    chk({e.name, "_latency"}, 32'(cyc - e.start_edge), 32'(e.lat));
                end
                n_done++;
            end
            done_prev = done;
        end
    end

    task automatic issue(input string nm, input logic [31:0] ta, input logic [31:0] tbv,
                         input logic ts, input logic [31:0] eq, input logic [31:0] er,
                         input logic ed, input int lat);
        exp_t e;
        e.q = eq; e.r = er; e.dbz = ed; e.lat = lat; e.start_edge = cyc + 1; e.name = nm;
        sb.push_back(e);
        a = ta; b = tbv; signed_op = ts; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a = ~ta; b = ~tbv; signed_op = ~ts;
    endtask

    task automatic wait_done(input string nm, input int n0);
        int i;
        i = 0;
        while (n_done <= n0 && i < 100) begin
            @(negedge clock);
            #1;
            i++;
        end
        chk({nm, "_completed"}, {31'b0, (n_done > n0)}, 32'd1);
        if (n_done <= n0 && sb.size() > 0) void'(sb.pop_back());
    endtask

    task automatic run_op(input string nm, input logic [31:0] ta, input logic [31:0] tbv,
                          input logic ts, input logic [31:0] eq, input logic [31:0] er,
                          input logic ed, input int lat);
        int n0;
        @(negedge clock);
        n0 = n_done;
        issue(nm, ta, tbv, ts, eq, er, ed, lat);
        wait_done(nm, n0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);

        run_op("u_100_7",     32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 33);
        run_op("s_m7_2",      32'hFFFFFFF9,   32'd2,          1'b1, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33);
        run_op("s_7_m2",      32'd7,          32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,   32'd1,          1'b0, 33);
        run_op("s_m100_m7",   32'hFFFFFF9C,   32'hFFFFFFF9,   1'b1, 32'd14,         32'hFFFFFFFE,   1'b0, 33);
        run_op("u_m7_2",      32'hFFFFFFF9,   32'd2,          1'b0, 32'h7FFFFFFC,   32'd1,          1'b0, 33);
        run_op("dbz_u",       32'h12345678,   32'd0,          1'b0, 32'hFFFFFFFF,   32'h12345678,   1'b1, 1);
        run_op("dbz_s",       32'h80000005,   32'd0,          1'b1, 32'hFFFFFFFF,   32'h80000005,   1'b1, 1);
        run_op("s_ovf",       32'h80000000,   32'hFFFFFFFF,   1'b1, 32'h80000000,   32'd0,          1'b0, 33);
        run_op("u_max_1",     32'hFFFFFFFF,   32'd1,          1'b0, 32'hFFFFFFFF,   32'd0,          1'b0, 33);
        run_op("u_max_max",   32'hFFFFFFFF,   32'hFFFFFFFF,   1'b0, 32'd1,          32'd0,          1'b0, 33);
        run_op("s_min_1",     32'h80000000,   32'd1,          1'b1, 32'h80000000,   32'd0,          1'b0, 33);
        run_op("u_5_big",     32'd5,          32'h80000000,   1'b0, 32'd0,          32'd5,          1'b0, 33);
        run_op("s_m5_3",      32'hFFFFFFFB,   32'd3,          1'b1, 32'hFFFFFFFF,   32'hFFFFFFFE,   1'b0, 33);

        // Second start while busy must be dropped, not queued.
        @(negedge clock);
        n0 = n_done;
        issue("busy_ign", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33);
        repeat (8) @(negedge clock);
        a = 32'd1; b = 32'd1; signed_op = 1'b0; start = 1'b1;
        chk("busy_high", {31'b0, busy}, 32'd1);
        @(negedge clock);
        start = 1'b0;
        wait_done("busy_ign", n0);
        repeat (45) @(negedge clock);
        chk("busy_ign_done_count", 32'(n_done - n0), 32'd1);

        // Reset mid-operation aborts without a done pulse.
        @(negedge clock);
        a = 32'd100; b = 32'd7; signed_op = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (14) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        n0 = n_done;
        repeat (45) @(negedge clock);
        chk("abort_no_done", 32'(n_done - n0), 32'd0);
        run_op("after_abort_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0, 33);

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
